adc_capture_ctrl: RTL and testbench

Capture sequencer in the ADC half-rate domain, downstream of the PS GPIO capture strobe. On a single-cycle capture request it writes a fixed-length block of ADC words, one per enabled channel, into the per-channel sample buffer RAMs. It then raises a per-channel done flag, which the GPIO interface returns to the PS. All logic runs on `adc_div2_clk`.

---
 rtl/adc_capture_ctrl.sv | 123 ++++++++++++
 tb/tb_adc_capture_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: writes one DEPTH-word block per enabled channel into the sample RAMs, then flags done.
// Optional holdoff before the first write is built only when ADC_CAPTURE_HOLDOFF_EN is defined.
module adc_capture_ctrl #(
  parameter int NCHAN  = 8,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 11
) (
  input  logic                    adc_div2_clk,
  input  logic                    adc_div2_rstn,
  input  logic                    capture_i,
  input  logic [NCHAN-1:0]        chan_en_i,
  input  logic [15:0]             delay_i,
  input  logic [NCHAN*DATA_W-1:0] adc_data_i,
  output logic [ADDR_W-1:0]       bram_addr_o,
  output logic [NCHAN-1:0]        bram_we_o,
  output logic [NCHAN*DATA_W-1:0] bram_data_o,
  output logic [NCHAN-1:0]        done_o,
  output logic                    busy_o,
  output logic                    missed_o
);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ADC_CAPTURE_HOLDOFF_EN
    S_HOLD,
`endif
    S_WRITE,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [NCHAN-1:0]          r_mask;
  logic [ADDR_W-1:0]         r_addr;
  logic [NCHAN-1:0]          r_we;
  logic [NCHAN*DATA_W-1:0]   r_data;
  logic [NCHAN-1:0]          r_done;
  logic                      r_busy;
  logic                      r_missed;
  logic                      w_last_addr;

`ifdef ADC_CAPTURE_HOLDOFF_EN
  logic [15:0]               r_cnt;
`else
  logic                      w_unused_delay;
  assign w_unused_delay = ^delay_i;
`endif

  assign w_last_addr = (r_addr == {ADDR_W{1'b1}});

  always_ff @(posedge adc_div2_clk or negedge adc_div2_rstn) begin
    if (!adc_div2_rstn) begin
      r_state  <= S_IDLE;
      r_mask   <= '0;
      r_addr   <= '0;
      r_we     <= '0;
      r_data   <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_missed <= 1'b0;
`ifdef ADC_CAPTURE_HOLDOFF_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_data <= adc_data_i;
      case (r_state)
        // DONE accepts a new request exactly like IDLE, so back-to-back captures need no gap
        S_IDLE, S_DONE: begin
          if (capture_i) begin
            r_mask   <= chan_en_i;
            r_done   <= '0;
            r_missed <= 1'b0;
            r_busy   <= 1'b1;
`ifdef ADC_CAPTURE_HOLDOFF_EN
            r_cnt    <= delay_i;
            if (delay_i != 16'd0) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_WRITE;
              r_addr  <= '0;
              r_we    <= chan_en_i;
            end
`else
            r_state  <= S_WRITE;
            r_addr   <= '0;
            r_we     <= chan_en_i;
`endif
          end
        end
`ifdef ADC_CAPTURE_HOLDOFF_EN
        S_HOLD: begin
          if (capture_i) r_missed <= 1'b1;
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_state <= S_WRITE;
            r_addr  <= '0;
            r_we    <= r_mask;
          end
        end
`endif
        S_WRITE: begin
          if (capture_i) r_missed <= 1'b1;
          if (w_last_addr) begin
            r_state <= S_DONE;
            r_we    <= '0;
            r_done  <= r_mask;
            r_busy  <= 1'b0;
          end else begin
            r_addr  <= r_addr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bram_addr_o = r_addr;
  assign bram_we_o   = r_we;
  assign bram_data_o = r_data;
  assign done_o      = r_done;
  assign busy_o      = r_busy;
  assign missed_o    = r_missed;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: full captures, partial masks, missed requests, abort by reset, holdoff.
module tb_adc_capture_ctrl;
  localparam int NCHAN  = 8;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DW     = NCHAN * DATA_W;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic              cap  = 1'b0;
  logic [NCHAN-1:0]  en   = '0;
  logic [15:0]       dly  = '0;
  logic [DW-1:0]     adc  = '0;
  logic [ADDR_W-1:0] addr;
  logic [NCHAN-1:0]  we;
  logic [NCHAN-1:0]  done;
  logic [DW-1:0]     bdata;
  logic              busy;
  logic              missed;

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;

  adc_capture_ctrl #(.NCHAN(NCHAN), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .adc_div2_clk  (clk),
    .adc_div2_rstn (rstn),
    .capture_i     (cap),
    .chan_en_i     (en),
    .delay_i       (dly),
    .adc_data_i    (adc),
    .bram_addr_o   (addr),
    .bram_we_o     (we),
    .bram_data_o   (bdata),
    .done_o        (done),
    .busy_o        (busy),
    .missed_o      (missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ramp(input int c);
    logic [DW-1:0] v;
    v = '0;
    for (int n = 0; n < NCHAN; n++)
      v[n*DATA_W +: DATA_W] = {32'(n), 32'hC0DE0000, 32'(c * 3), 32'(c)};
    return v;
  endfunction

  function automatic logic outs_zero();
    return (addr === '0) && (we === '0) && (bdata === '0) && (done === '0) &&
           (busy === 1'b0) && (missed === 1'b0);
  endfunction

  // Cycle 0 is the cycle in which capture_i is high; checks run at each following falling edge.
  task automatic run_capture(input string tag, input logic [NCHAN-1:0] mask, input int d_in,
                             input int d_exp, input bit started, input int p1, input int p2,
                             input int stop_k, input int next_mask);
    int  end_k, last_k, exp_wr;
    int  writes, we_err, addr_err, data_err, busy_err, done_err, miss_err;
    bit  exp_miss;
    end_k  = d_exp + DEPTH + 1;
    writes = 0; we_err = 0; addr_err = 0; data_err = 0;
    busy_err = 0; done_err = 0; miss_err = 0;
    exp_miss = 1'b0;
    if (!started) begin
      @(negedge clk);
      en  = mask;
      dly = 16'(d_in);
      cap = 1'b1;
      t++;
      adc = ramp(t);
    end
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      if (bdata !== adc) data_err++;
      if (k > d_exp && k <= d_exp + DEPTH) begin
        if (we === mask) writes++; else we_err++;
        if (addr !== ADDR_W'(k - d_exp - 1)) addr_err++;
      end else if (we !== '0) begin
        we_err++;
      end
      if (busy !== (k < end_k)) busy_err++;
      if (done !== ((k == end_k) ? mask : {NCHAN{1'b0}})) done_err++;
      if (missed !== exp_miss) miss_err++;
      if (k == stop_k) break;
      cap = (k == p1) || (k == p2);
      if (cap) exp_miss = 1'b1;
      if (k == 1) begin
        en  = ~mask;
        dly = 16'hFFFF;
      end
      if (k == end_k && next_mask >= 0) begin
        cap = 1'b1;
        en  = NCHAN'(next_mask);
        dly = 16'd0;
      end
      t++;
      adc = ramp(t);
    end
    last_k = (stop_k > 0) ? stop_k : end_k;
    exp_wr = last_k - d_exp;
    if (exp_wr < 0) exp_wr = 0;
    if (exp_wr > DEPTH) exp_wr = DEPTH;
    check({tag, ".writes"}, writes, exp_wr);
    check({tag, ".we"},     we_err, 0);
    check({tag, ".addr"},   addr_err, 0);
    check({tag, ".data"},   data_err, 0);
    check({tag, ".busy"},   busy_err, 0);
    check({tag, ".done"},   done_err, 0);
    check({tag, ".missed"}, miss_err, 0);
  endtask

  initial begin
    int bad;
    #1;
    check("rst.outs_zero", outs_zero(), 1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("idle.outs_zero", outs_zero(), 1);

    run_capture("full_ff",  8'hFF, 0, 0, 1'b0, -1, -1, -1, -1);
    run_capture("m05",      8'h05, 0, 0, 1'b0, -1, -1, -1, 8'h0F);
    run_capture("chain0f",  8'h0F, 0, 0, 1'b1, -1, -1, -1, -1);
    run_capture("pulses",   8'hA5, 0, 0, 1'b0, 10, 1000, -1, -1);
    run_capture("clr_miss", 8'h3C, 0, 0, 1'b0, -1, -1, -1, -1);

    run_capture("abort",    8'hFF, 0, 0, 1'b0, -1, -1, 501, -1);
    #1 rstn = 1'b0;
    #1 check("abort.outs_zero", outs_zero(), 1);
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (!outs_zero()) bad++;
    end
    check("abort.held_zero", bad, 0);
    @(negedge clk);
    rstn = 1'b1;
    run_capture("post_rst", 8'hFF, 0, 0, 1'b0, -1, -1, -1, -1);

`ifdef ADC_CAPTURE_HOLDOFF_EN
    run_capture("hold100",  8'hFF, 100, 100, 1'b0, -1, -1, -1, -1);
    run_capture("hold0",    8'hC3, 0, 0, 1'b0, -1, -1, -1, -1);
`else
    run_capture("nohold",   8'hFF, 100, 0, 1'b0, -1, -1, -1, -1);
`endif
    run_capture("mask00",   8'h00, 0, 0, 1'b0, -1, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
